shift_reg_univ: RTL
===================

SHIFT_REG_UNIV -- requirements
Module: shift_reg_univ

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, register width in bits (legal range 2..64).
REQ-002 The module SHALL have parameter INIT, default 0, WIDTH-bit value loaded into q on reset.
REQ-003 The module SHALL have port clk  input  1  rising-edge clock for all state.
REQ-004 The module SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 The module SHALL have port en  input  1  clock enable; when low, all registered state holds.
REQ-006 The module SHALL have port mode  input  2  operation select: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
REQ-007 The module SHALL have port sin_r  input  1  serial bit entering q[WIDTH-1] on a shift right.
REQ-008 The module SHALL have port sin_l  input  1  serial bit entering q[0] on a shift left.
REQ-009 The module SHALL have port d  input  WIDTH  parallel load data.
REQ-010 The module SHALL have port q  output  WIDTH  registered register contents.
REQ-011 The module SHALL have port sout_r  output  1  combinational copy of q[0].
REQ-012 The module SHALL have port sout_l  output  1  combinational copy of q[WIDTH-1].
REQ-013 The module SHALL have port cnt  output  $clog2(WIDTH)  registered count of shifts since the last load, reset or word completion.
REQ-014 The module SHALL have port done  output  1  registered one-cycle pulse marking word completion.

Function
REQ-015 All state SHALL update only on a rising clk edge with en=1 and rst_n=1.
REQ-016 With en=0: q and cnt SHALL hold, and done SHALL be 0 on the next edge.
REQ-017 Mode 00: q and cnt SHALL hold, and done SHALL be 0 on the next edge.
REQ-018 Mode 01: q SHALL become {sin_r, q[WIDTH-1:1]} one edge later.
REQ-019 Mode 10: q SHALL become {q[WIDTH-2:0], sin_l} one edge later.
REQ-020 Mode 11: q SHALL become d, cnt SHALL become 0, and done SHALL be 0 on the next edge.
REQ-021 On each shift (mode 01 or 10): cnt SHALL increment by 1 when cnt < WIDTH-1; when cnt = WIDTH-1, cnt SHALL wrap to 0 and done SHALL be 1 for exactly the following cycle.
REQ-022 On every shift that does not complete a word, done SHALL be 0.
REQ-023 A direction change mid-word SHALL NOT reset cnt; both shift directions count toward the same word.
REQ-024 Latency from the input edge to q, cnt and done SHALL be exactly one clock; sout_r and sout_l SHALL have zero latency from q.

Reset
REQ-025 While rst_n=0, independent of clk: q SHALL equal INIT, cnt SHALL equal 0, and done SHALL equal 0.
REQ-026 Reset asserted mid-word SHALL discard the partial count; the first shift after release SHALL start a new word at cnt=0.
REQ-027 Reset deassertion SHALL take effect on the first rising clk edge after rst_n=1.

Configuration
REQ-028 With macro SHIFT_ROTATE_EN defined, mode 01 SHALL produce {q[0], q[WIDTH-1:1]} and mode 10 SHALL produce {q[WIDTH-2:0], q[WIDTH-1]}, ignoring sin_r and sin_l; cnt and done SHALL behave as in REQ-021.
REQ-029 Without SHIFT_ROTATE_EN, the shift modes SHALL use sin_r and sin_l as in REQ-018 and REQ-019, and the rotate logic SHALL NOT be present.

Verification (WIDTH=8, INIT=0)
REQ-030 Load test: rst_n pulse, then mode=11 with d=8'hA5 for one edge -> q=8'hA5, cnt=0, done=0.
REQ-031 Shift-right test: from q=8'hA5, mode=01 with sin_r=1 for one edge -> q=8'hD2 and sout_r=0; without the macro, mode=10 with sin_l=0 from 8'hA5 -> q=8'h4A.
REQ-032 Word-completion test: 8 consecutive mode=01 edges -> cnt goes 1..7 then 0, and done=1 only in the cycle after the 8th edge.
REQ-033 Enable/hold test: en=0 for 3 edges mid-word, or mode=00 -> q and cnt unchanged and done=0; counting resumes from the same cnt afterwards.
REQ-034 Mid-word reset test: assert rst_n=0 asynchronously between edges at cnt=5 -> q=8'h00 and cnt=0 immediately; after release, 8 shifts are required to produce done.
REQ-035 Rotate test (SHIFT_ROTATE_EN defined): from q=8'hA5, mode=10 for one edge -> q=8'h4B; mode=01 for one edge from 8'hA5 -> q=8'hD2 regardless of sin_r.

Source files
------------

// File: rtl/shift_reg_univ.sv
// Universal shift register: hold, shift right, shift left and parallel load,
// with a shared per-word shift counter. Define SHIFT_ROTATE_EN to turn the shifts into rotates.
module shift_reg_univ #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [1:0]               mode,
  input  logic                     sin_r,
  input  logic                     sin_l,
  input  logic [WIDTH-1:0]         d,
  output logic [WIDTH-1:0]         q,
  output logic                     sout_r,
  output logic                     sout_l,
  output logic [$clog2(WIDTH)-1:0] cnt,
  output logic                     done
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  logic [WIDTH-1:0] q_q, q_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] shr_val, shl_val;

`ifdef SHIFT_ROTATE_EN
  logic unused_sin;
  assign unused_sin = sin_r ^ sin_l;
  assign shr_val    = {q_q[0], q_q[WIDTH-1:1]};
  assign shl_val    = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
`else
  assign shr_val = {sin_r, q_q[WIDTH-1:1]};
  assign shl_val = {q_q[WIDTH-2:0], sin_l};
`endif

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    q_d    = q_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (en) begin
      case (mode_e'(mode))
        MODE_SHR, MODE_SHL: begin
          q_d = (mode_e'(mode) == MODE_SHR) ? shr_val : shl_val;
          // Both directions feed the same word; the WIDTH-th shift closes it.
          if (cnt_q == CW'(WIDTH - 1)) begin
            cnt_d  = '0;
            done_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        MODE_LOAD: begin
          q_d   = d;
          cnt_d = '0;
        end
        default: ;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q    <= INIT;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign q      = q_q;
  assign sout_r = q_q[0];
  assign sout_l = q_q[WIDTH-1];
  assign cnt    = cnt_q;
  assign done   = done_q;

endmodule
